// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the pipeline
// MEM stage (port 0) and the loader/debug port (port 1); one access per 2 cycles.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_port;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_any;
  logic        w_win;
  logic        w_grant;
  logic        w_illegal;
  logic        w_valid_rd;

  assign w_any   = req0 | req1;
  // Under contention the port not named by the last-grant pointer wins.
  assign w_win   = req1 & (~req0 | ~r_last);
  assign w_grant = w_any & ((r_state == IDLE) | (r_state == RESP));

  assign w_illegal  = (r_addr[1:0] != 2'b00) | ({2'b00, r_addr[31:2]} >= 32'(DEPTH));
  assign w_valid_rd = (r_state == ISSUE) & ~w_illegal & ~r_we;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = RESP;
      RESP:    w_next = w_any ? ISSUE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      ISSUE: begin
        gnt0      = ~r_port;
        gnt1      = r_port;
        mem_read  = ~w_illegal & ~r_we;
        mem_write = ~w_illegal & r_we;
      end
      RESP: begin
        done0 = ~r_port;
        done1 = r_port;
        err0  = ~r_port & w_illegal;
        err1  = r_port & w_illegal;
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_port  <= w_win;
        r_last  <= w_win;
        r_we    <= w_win ? we1    : we0;
        r_addr  <= w_win ? addr1  : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
      end
      // Read data lives only in the RESP cycle; any other edge clears it.
      if (r_state == ISSUE) begin
        r_rdata0 <= (w_valid_rd & ~r_port) ? mem_rdata : '0;
        r_rdata1 <= (w_valid_rd &  r_port) ? mem_rdata : '0;
      end else begin
        r_rdata0 <= '0;
        r_rdata1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word memory model and
// hand-computed expectations for each step.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  logic        load = 1'b1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h0101_0101;
      mem[0] <= 32'hCAFE_F00D;
      mem[1] <= 32'h1111_1111;
      mem[3] <= 32'hDEAD_BEEF;
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] g, input logic [31:0] d,
                          input logic [31:0] e, input logic [31:0] r0, input logic [31:0] r1);
    chk({tag, "_gnt"},   {30'd0, gnt1, gnt0},   g);
    chk({tag, "_done"},  {30'd0, done1, done0}, d);
    chk({tag, "_err"},   {30'd0, err1, err0},   e);
    chk({tag, "_rdata0"}, rdata0, r0);
    chk({tag, "_rdata1"}, rdata1, r1);
  endtask

  initial begin
    tick();
    load = 1'b0;
    tick();
    chk_resp("reset", 0, 0, 0, 0, 0);
    chk("reset_mem_en", {30'd0, mem_read, mem_write}, 0);
    chk("reset_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // Single read on port 0
    req0 = 1; we0 = 0; addr0 = 32'h0C;
    tick();
    chk_resp("rd0_issue", 1, 0, 0, 0, 0);
    chk("rd0_mem_en", {30'd0, mem_read, mem_write}, 2);
    chk("rd0_mem_addr", mem_addr, 32'h0C);
    req0 = 0;
    tick();
    chk_resp("rd0_resp", 0, 1, 0, 32'hDEAD_BEEF, 0);
    chk("rd0_resp_en", {30'd0, mem_read, mem_write}, 0);
    tick();
    chk_resp("rd0_idle", 0, 0, 0, 0, 0);

    // Write then read on port 1
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h1234_5678;
    tick();
    chk_resp("wr1_issue", 2, 0, 0, 0, 0);
    chk("wr1_mem_en", {30'd0, mem_read, mem_write}, 1);
    chk("wr1_mem_addr", mem_addr, 32'h20);
    chk("wr1_mem_wdata", mem_wdata, 32'h1234_5678);
    req1 = 0;
    tick();
    chk_resp("wr1_resp", 0, 2, 0, 0, 0);
    chk("wr1_resp_en", {30'd0, mem_read, mem_write}, 0);
    chk("wr1_mem8", mem[8], 32'h1234_5678);
    chk("wr1_mem_addr_hold", mem_addr, 32'h20);
    tick();
    req1 = 1; we1 = 0; addr1 = 32'h20;
    tick();
    chk("rd1_mem_en", {30'd0, mem_read, mem_write}, 2);
    req1 = 0;
    tick();
    chk_resp("rd1_resp", 0, 2, 0, 0, 32'h1234_5678);
    tick();

    // Contention: last grant was port 1, so port 0 goes first
    req0 = 1; we0 = 0; addr0 = 32'h0C;
    req1 = 1; we1 = 0; addr1 = 32'h20;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (i % 4)
        0: chk_resp($sformatf("cont%0d", i), 1, 0, 0, 0, 0);
        1: chk_resp($sformatf("cont%0d", i), 0, 1, 0, 32'hDEAD_BEEF, 0);
        2: chk_resp($sformatf("cont%0d", i), 2, 0, 0, 0, 0);
        default: chk_resp($sformatf("cont%0d", i), 0, 2, 0, 0, 32'h1234_5678);
      endcase
    end
    req0 = 0; req1 = 0;
    tick();
    chk_resp("cont_idle", 0, 0, 0, 0, 0);

    // Illegal: misaligned read, then out-of-range write
    req0 = 1; we0 = 0; addr0 = 32'h06;
    tick();
    chk_resp("mis_issue", 1, 0, 0, 0, 0);
    chk("mis_mem_en", {30'd0, mem_read, mem_write}, 0);
    req0 = 0;
    tick();
    chk_resp("mis_resp", 0, 1, 1, 0, 0);
    tick();
    req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 32'hA5A5_A5A5;
    tick();
    chk_resp("oor_issue", 2, 0, 0, 0, 0);
    chk("oor_mem_en", {30'd0, mem_read, mem_write}, 0);
    req1 = 0;
    tick();
    chk_resp("oor_resp", 0, 2, 2, 0, 0);
    chk("oor_mem0", mem[0], 32'hCAFE_F00D);
    tick();

    // Reset during ISSUE of a write to word 1
    req0 = 1; we0 = 1; addr0 = 32'h04; wdata0 = 32'hFFFF_FFFF;
    tick();
    chk("rst_pre_en", {30'd0, mem_read, mem_write}, 1);
    rst_n = 0;
    #1;
    chk("rst_async_en", {30'd0, mem_read, mem_write}, 0);
    chk_resp("rst_async", 0, 0, 0, 0, 0);
    chk("rst_mem_addr", mem_addr, 0);
    req0 = 0;
    tick();
    chk("rst_mem1", mem[1], 32'h1111_1111);
    rst_n = 1;
    tick();
    req0 = 1; we0 = 0; addr0 = 32'h0C;
    req1 = 1; we1 = 0; addr1 = 32'h20;
    tick();
    chk_resp("rst_first_gnt", 1, 0, 0, 0, 0);
    req0 = 0; req1 = 0;
    tick();
    chk_resp("rst_first_resp", 0, 1, 0, 32'hDEAD_BEEF, 0);
    tick();

    // Back-to-back: port 1 requests during port 0's RESP
    req0 = 1; we0 = 0; addr0 = 32'h0C;
    tick();
    req0 = 0;
    tick();
    chk_resp("b2b_resp0", 0, 1, 0, 32'hDEAD_BEEF, 0);
    req1 = 1; we1 = 0; addr1 = 32'h20;
    tick();
    chk_resp("b2b_gnt1", 2, 0, 0, 0, 0);
    req1 = 0;
    tick();
    chk_resp("b2b_resp1", 0, 2, 0, 0, 32'h1234_5678);
    tick();
    chk_resp("b2b_idle", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port word data memory between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is the loader/debug port.
- Arbitrates round-robin and registers the winning command.
- Drives the memory for exactly one cycle, captures read data, and returns a done/err response to the winner.
- Checks alignment and range before touching the memory.

Parameters:
DEPTH, 64, memory size in 32-bit words; must match the memory instance; valid word index range is 0..DEPTH-1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0 / req1  input  1  access request from port 0 / 1
we0 / we1  input  1  1 = write, 0 = read; valid with req
addr0 / addr1  input  32  byte address; valid with req
wdata0 / wdata1  input  32  write data; valid with req
gnt0 / gnt1  output  1  one-cycle pulse: command captured, port is in ISSUE
done0 / done1  output  1  one-cycle pulse: access complete
err0 / err1  output  1  with done: access rejected, memory untouched
rdata0 / rdata1  output  32  read data; valid while done is high
mem_read  output  1  to memory read enable
mem_write  output  1  to memory write enable, committed at clk edge
mem_addr  output  32  to memory byte address
mem_wdata  output  32  to memory write data
mem_rdata  input  32  from memory combinational read data

Behaviour:
- Reset values: state IDLE; all outputs 0; last-grant pointer = 1, so port 0 wins the first contention.
- Reset is asynchronous. Asserting rst_n mid-access drops the access immediately, and mem_write goes low with no commit.
- State machine: IDLE, ISSUE, RESP.
- IDLE:
  - No request → stay in IDLE.
  - Any request at the clk edge → latch the winner's we/addr/wdata and its port id, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - gnt of the winner = 1.
  - mem_addr = latched addr, mem_wdata = latched wdata.
  - Valid command: mem_read = ~we, mem_write = we.
  - Illegal command: both enables = 0.
  - At the clk edge: a valid write commits in the memory; a valid read captures mem_rdata into the winner's rdata register. Go to RESP.
- RESP (1 cycle):
  - done of the winner = 1.
  - err = 1 if the command was illegal.
  - rdata = captured data on a valid read, else 0.
  - The other port's rdata stays 0.
  - Arbitration runs here as in IDLE: a pending request → ISSUE next cycle; none → IDLE.
- Peak throughput is one access per 2 cycles.
- Latency: request sampled at edge N → gnt in cycle N+1 → done/rdata in cycle N+2.
- Illegal command, checked on the latched address:
  - addr[1:0] != 0, or
  - addr[31:2] >= DEPTH.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - req during its own gnt cycle is ignored.
  - req still high in the following cycle (RESP) is a new request.
- Round-robin:
  - Only one port requesting → that port wins.
  - Both requesting → the port not equal to the last-grant pointer wins.
  - The pointer updates to the winner on every grant.
- gnt, done, and err never assert for both ports in the same cycle.
- mem_addr and mem_wdata hold their last values outside ISSUE. The memory ignores them because both enables are 0.

Test Plan:
- Single read: memory word 3 preloaded 0xDEADBEEF; req0 read addr 0x0C at edge N → gnt0 in N+1 with mem_read=1, mem_addr=0x0C → done0=1, err0=0, rdata0=0xDEADBEEF in N+2.
- Write then read on port 1: write 0x12345678 to 0x20 → mem_write=1 for exactly one cycle; a following read of 0x20 → rdata1=0x12345678.
- Contention: req0 and req1 held high continuously, each reasserting after its gnt → grants alternate 0,1,0,1; one done every 2 cycles; no cycle with both gnt high.
- Illegal address: read 0x06 (misaligned), then write 0x100 (index 64 with DEPTH=64) → no mem_read/mem_write pulse; done/err=1, rdata=0; memory contents unchanged.
- Reset mid-write: rst_n low during ISSUE of a write of 0xFFFFFFFF to 0x04 → mem_write drops immediately; word 1 unchanged; all outputs 0; after release, the first contended grant goes to port 0.
- Back-to-back from RESP: req1 asserted during port 0's RESP → gnt1 in the next cycle (no IDLE cycle in between).
